// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon Says round controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package simon_pkg;

   localparam int MAX_STEPS = 32;
   localparam int IDX_W     = $clog2(MAX_STEPS);   // step index width (5)
   localparam int LEN_W     = IDX_W + 1;           // round length width (6)

   // Colour code: 0..3 select one LED, any code with bit 2 set is invalid.
   typedef logic [2:0] colour_t;

   localparam colour_t COL_RED    = 3'd0;
   localparam colour_t COL_GREEN  = 3'd1;
   localparam colour_t COL_YELLOW = 3'd2;
   localparam colour_t COL_BLUE   = 3'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHOW_ON,
      ST_SHOW_OFF,
      ST_RELEASE,
      ST_WAIT_IN,
      ST_WIN,
      ST_FAIL
   } seq_state_t;

   // LED pattern for a colour; invalid codes light nothing.
   function automatic logic [3:0] colour_onehot(input colour_t c);
      logic [3:0] oh;
      oh = 4'b0000;
      if (!c[2]) begin
         oh[c[1:0]] = 1'b1;
      end
      return oh;
   endfunction

   // True when exactly one button is pressed.
   function automatic logic is_onehot4(input logic [3:0] v);
      return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
   endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter; done_o flags the last cycle of a loaded interval.
// Latency: a load of N makes done_o high N-1 cycles after the loading edge.
// Backpressure: none; a new load overrides any interval in progress.
module seq_timer #(
   parameter int W = 5
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         done_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: load wins, otherwise count down and park at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A load of N spends N cycles in the owning state: the last one is count 1.
   assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/simon_sequencer.sv
// Simon Says round controller: plays N colours on the LEDs, then checks N presses.
// Latency: every output is a register of the current state, one cycle behind it.
// Backpressure: none; start is ignored while busy, inputs are sampled each cycle.
module simon_sequencer
   import simon_pkg::*;
#(
   parameter int ON_CYCLES      = 4,
   parameter int OFF_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 20
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [LEN_W-1:0]        round_len,
   input  colour_t [MAX_STEPS-1:0] segment,
   input  logic [3:0]              player_input,
   output logic [3:0]              disp,
   output logic [IDX_W-1:0]        check_round,
   output logic                    busy,
   output logic                    input_phase,
   output logic                    round_won,
   output logic                    round_fail
);

   // One timer serves all three intervals, so size it for the longest one.
   localparam int MAX_ON_OFF   = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int MAX_INTERVAL = (MAX_ON_OFF > TIMEOUT_CYCLES) ? MAX_ON_OFF : TIMEOUT_CYCLES;
   localparam int CNT_W        = $clog2(MAX_INTERVAL + 1);

   localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES);
   localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES);
   localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_STEPS);

   seq_state_t              state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [LEN_W-1:0]        len_q, len_d;
   colour_t [MAX_STEPS-1:0] snap_q, snap_d;

   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_done;

   logic [3:0]       disp_q, disp_d;
   logic [IDX_W-1:0] check_q, check_d;
   logic             busy_q, busy_d;
   logic             inph_q, inph_d;
   logic             won_q, won_d;
   logic             fail_q, fail_d;

   logic [3:0] expect_oh;
   logic       last_step;
   logic       press_ok;

   seq_timer #(
      .W (CNT_W)
   ) u_timer (
      .clk_i      (clk),
      .reset_i    (reset),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .done_o     (tmr_done)
   );

   assign expect_oh = colour_onehot(snap_q[idx_q]);
   assign last_step = ({1'b0, idx_q} == (len_q - LEN_W'(1)));
   // An invalid slot gives expect_oh = 0, which no non-zero press can equal.
   assign press_ok  = is_onehot4(player_input) && (player_input == expect_oh);

   // Next-state logic: each state entry reloads the timer for its interval.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      len_d    = len_q;
      snap_d   = snap_q;
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state_q)
         ST_IDLE: begin
            if (start && (round_len != '0)) begin
               len_d    = (round_len > LEN_MAX) ? LEN_MAX : round_len;
               snap_d   = segment;
               idx_d    = '0;
               state_d  = ST_SHOW_ON;
               tmr_load = 1'b1;
               tmr_val  = ON_LOAD;
            end
         end
         ST_SHOW_ON: begin
            if (tmr_done) begin
               state_d  = ST_SHOW_OFF;
               tmr_load = 1'b1;
               tmr_val  = OFF_LOAD;
            end
         end
         ST_SHOW_OFF: begin
            if (tmr_done) begin
               tmr_load = 1'b1;
               if (last_step) begin
                  idx_d   = '0;
                  state_d = ST_RELEASE;
                  tmr_val = TO_LOAD;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = ST_SHOW_ON;
                  tmr_val = ON_LOAD;
               end
            end
         end
         ST_RELEASE: begin
            // Timeout is checked first so it beats a release in the same cycle.
            if (tmr_done) begin
               state_d = ST_FAIL;
            end else if (player_input == 4'b0000) begin
               state_d  = ST_WAIT_IN;
               tmr_load = 1'b1;
               tmr_val  = TO_LOAD;
            end
         end
         ST_WAIT_IN: begin
            if (tmr_done) begin
               state_d = ST_FAIL;
            end else if (player_input != 4'b0000) begin
               if (!press_ok) begin
                  state_d = ST_FAIL;
               end else if (last_step) begin
                  state_d = ST_WIN;
               end else begin
                  idx_d    = idx_q + IDX_W'(1);
                  state_d  = ST_RELEASE;
                  tmr_load = 1'b1;
                  tmr_val  = TO_LOAD;
               end
            end
         end
         ST_WIN:  state_d = ST_IDLE;
         ST_FAIL: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and round context registers; reset discards any latched round.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         len_q   <= '0;
         snap_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         snap_q  <= snap_d;
      end
   end

   // Output decode from the current state, registered on the next edge.
   always_comb begin
      disp_d  = 4'b0000;
      check_d = '0;
      busy_d  = 1'b0;
      inph_d  = 1'b0;
      won_d   = 1'b0;
      fail_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
         end
         ST_SHOW_ON: begin
            busy_d  = 1'b1;
            check_d = idx_q;
            disp_d  = expect_oh;
         end
         ST_SHOW_OFF: begin
            busy_d  = 1'b1;
            check_d = idx_q;
         end
         ST_RELEASE, ST_WAIT_IN: begin
            busy_d  = 1'b1;
            inph_d  = 1'b1;
            check_d = idx_q;
            disp_d  = player_input;
         end
         ST_WIN: begin
            busy_d = 1'b1;
            won_d  = 1'b1;
         end
         ST_FAIL: begin
            busy_d = 1'b1;
            fail_d = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         disp_q  <= 4'b0000;
         check_q <= '0;
         busy_q  <= 1'b0;
         inph_q  <= 1'b0;
         won_q   <= 1'b0;
         fail_q  <= 1'b0;
      end else begin
         disp_q  <= disp_d;
         check_q <= check_d;
         busy_q  <= busy_d;
         inph_q  <= inph_d;
         won_q   <= won_d;
         fail_q  <= fail_d;
      end
   end

   assign disp        = disp_q;
   assign check_round = check_q;
   assign busy        = busy_q;
   assign input_phase = inph_q;
   assign round_won   = won_q;
   assign round_fail  = fail_q;

endmodule

// File: tb/tb_simon_sequencer.sv
// Directed bench for simon_sequencer: playback timing, press checking, timeouts, edge cases.
// Latency: inputs driven and outputs sampled just after each falling clock edge.
// Backpressure: n/a.
module tb_simon_sequencer;
   import simon_pkg::*;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    start;
   logic [5:0]              round_len;
   colour_t [MAX_STEPS-1:0] segment;
   logic [3:0]              player_input;
   logic [3:0]              disp;
   logic [4:0]              check_round;
   logic                    busy;
   logic                    input_phase;
   logic                    round_won;
   logic                    round_fail;

   int n_checks = 0;
   int n_fail   = 0;
   int won_cnt  = 0;
   int fail_cnt = 0;

   simon_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .round_len    (round_len),
      .segment      (segment),
      .player_input (player_input),
      .disp         (disp),
      .check_round  (check_round),
      .busy         (busy),
      .input_phase  (input_phase),
      .round_won    (round_won),
      .round_fail   (round_fail)
   );

   always #5 clk = ~clk;

   // Pulse tallies, sampled on the falling edge.
   always @(negedge clk) begin
      if (round_won === 1'b1) won_cnt++;
      if (round_fail === 1'b1) fail_cnt++;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; round_len = '0; segment = '0; player_input = 4'b0000;
      cyc(2);
      reset = 1'b0;
      cyc(1);
   endtask

   task automatic set_seg_base();
      segment = '0;
      segment[0] = COL_RED; segment[1] = COL_YELLOW; segment[2] = COL_GREEN;
   endtask

   // Pulse start for one cycle; returns one cycle after the sampling edge.
   task automatic begin_round(input logic [5:0] len);
      round_len = len; start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   task automatic wait_input_phase(input string tag, input int limit);
      int k;
      k = 0;
      while (input_phase !== 1'b1 && k < limit) begin
         cyc(1);
         k++;
      end
      n_checks++;
      if (input_phase !== 1'b1) begin
         n_fail++;
         $display("FAIL %s wait_input_phase: input_phase=%b after %0d cycles, required 1", tag, input_phase, k);
      end
   endtask

   task automatic press1(input logic [3:0] v);
      player_input = v;
      cyc(1);
      player_input = 4'b0000;
      cyc(1);
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; round_len = '0; segment = '0; player_input = 4'b1111;
      cyc(1);
      n_checks++;
      if ({disp, check_round, busy, input_phase, round_won, round_fail} !== 13'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got disp=%b cr=%0d busy=%b ip=%b won=%b fail=%b, required all 0",
                  disp, check_round, busy, input_phase, round_won, round_fail);
      end
      player_input = 4'b0000;
      reset = 1'b0;
      cyc(2);
      n_checks++;
      if (busy !== 1'b0 || disp !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_idle: got busy=%b disp=%b, required 0/0000", busy, disp);
      end
   endtask

   task automatic test_playback();
      logic [3:0] exp_on [3];
      logic [3:0] exp_d;
      exp_on[0] = 4'b0001; exp_on[1] = 4'b0100; exp_on[2] = 4'b0010;
      do_reset();
      set_seg_base();
      begin_round(6'd3);
      n_checks++;
      if (busy !== 1'b0 || disp !== 4'b0000) begin
         n_fail++;
         $display("FAIL play_first_edge: got busy=%b disp=%b, required 0/0000", busy, disp);
      end
      for (int s = 0; s < 18; s++) begin
         cyc(1);
         exp_d = ((s % 6) < 4) ? exp_on[s / 6] : 4'b0000;
         n_checks++;
         if (disp !== exp_d || check_round !== 5'(s / 6) || busy !== 1'b1 || input_phase !== 1'b0) begin
            n_fail++;
            $display("FAIL play_slot%0d: got disp=%b cr=%0d busy=%b ip=%b, required %b/%0d/1/0",
                     s, disp, check_round, busy, input_phase, exp_d, s / 6);
         end
      end
      cyc(1);
      n_checks++;
      if (input_phase !== 1'b1 || check_round !== 5'd0 || disp !== 4'b0000) begin
         n_fail++;
         $display("FAIL play_input_phase: got ip=%b cr=%0d disp=%b, required 1/0/0000", input_phase, check_round, disp);
      end
   endtask

   // Continues the round left in WAIT_IN by test_playback.
   task automatic test_win();
      int w0, f0;
      w0 = won_cnt; f0 = fail_cnt;
      player_input = 4'b0001;
      cyc(1);
      n_checks++;
      if (disp !== 4'b0001) begin
         n_fail++;
         $display("FAIL win_mirror: got disp=%b, required 0001", disp);
      end
      player_input = 4'b0000;
      cyc(1);
      press1(4'b0100);
      player_input = 4'b0010;
      cyc(1);
      player_input = 4'b0000;
      n_checks++;
      if (round_won !== 1'b0) begin
         n_fail++;
         $display("FAIL win_early: got won=%b, required 0", round_won);
      end
      cyc(1);
      n_checks++;
      if (round_won !== 1'b1 || busy !== 1'b1 || round_fail !== 1'b0) begin
         n_fail++;
         $display("FAIL win_pulse: got won=%b busy=%b fail=%b, required 1/1/0", round_won, busy, round_fail);
      end
      cyc(1);
      n_checks++;
      if (round_won !== 1'b0 || busy !== 1'b0 || won_cnt - w0 !== 1 || fail_cnt !== f0) begin
         n_fail++;
         $display("FAIL win_end: got won=%b busy=%b wins=%0d fails=%0d, required 0/0/1/0",
                  round_won, busy, won_cnt - w0, fail_cnt - f0);
      end
   endtask

   task automatic test_wrong_press();
      int w0;
      do_reset();
      set_seg_base();
      begin_round(6'd3);
      wait_input_phase("wrong", 40);
      w0 = won_cnt;
      press1(4'b0001);
      player_input = 4'b1000;
      cyc(1);
      player_input = 4'b0000;
      n_checks++;
      if (round_fail !== 1'b0) begin
         n_fail++;
         $display("FAIL wrong_early: got fail=%b, required 0", round_fail);
      end
      cyc(1);
      n_checks++;
      if (round_fail !== 1'b1 || round_won !== 1'b0) begin
         n_fail++;
         $display("FAIL wrong_pulse: got fail=%b won=%b, required 1/0", round_fail, round_won);
      end
      cyc(1);
      n_checks++;
      if (round_fail !== 1'b0 || busy !== 1'b0 || won_cnt !== w0) begin
         n_fail++;
         $display("FAIL wrong_end: got fail=%b busy=%b wins=%0d, required 0/0/0", round_fail, busy, won_cnt - w0);
      end
   endtask

   task automatic test_multi_press();
      do_reset();
      set_seg_base();
      begin_round(6'd3);
      wait_input_phase("multi", 40);
      player_input = 4'b0101;
      cyc(1);
      player_input = 4'b0000;
      cyc(1);
      n_checks++;
      if (round_fail !== 1'b1 || round_won !== 1'b0) begin
         n_fail++;
         $display("FAIL multi_press: got fail=%b won=%b, required 1/0", round_fail, round_won);
      end
   endtask

   task automatic test_held_button();
      int w0, f0;
      do_reset();
      set_seg_base();
      begin_round(6'd3);
      cyc(10);
      player_input = 4'b0001;
      wait_input_phase("held", 40);
      w0 = won_cnt; f0 = fail_cnt;
      n_checks++;
      if (disp !== 4'b0001) begin
         n_fail++;
         $display("FAIL held_mirror: got disp=%b, required 0001", disp);
      end
      cyc(3);
      n_checks++;
      if (input_phase !== 1'b1 || check_round !== 5'd0 || fail_cnt !== f0) begin
         n_fail++;
         $display("FAIL held_not_counted: got ip=%b cr=%0d fails=%0d, required 1/0/0", input_phase, check_round, fail_cnt - f0);
      end
      player_input = 4'b0000;
      cyc(1);
      press1(4'b0001);
      press1(4'b0100);
      press1(4'b0010);
      cyc(2);
      n_checks++;
      if (won_cnt - w0 !== 1 || fail_cnt !== f0) begin
         n_fail++;
         $display("FAIL held_round: got wins=%0d fails=%0d, required 1/0", won_cnt - w0, fail_cnt - f0);
      end
   endtask

   task automatic test_timeout();
      logic exp_f;
      do_reset();
      segment = '0; segment[0] = COL_BLUE;
      begin_round(6'd1);
      wait_input_phase("timeout", 40);
      for (int i = 1; i <= 21; i++) begin
         cyc(1);
         exp_f = (i == 21);
         n_checks++;
         if (round_fail !== exp_f) begin
            n_fail++;
            $display("FAIL timeout_cycle%0d: got fail=%b, required %b", i, round_fail, exp_f);
         end
      end
      // A correct press landing on the final timeout cycle still fails.
      do_reset();
      segment = '0; segment[0] = COL_BLUE;
      begin_round(6'd1);
      wait_input_phase("timeout_tie", 40);
      cyc(19);
      player_input = 4'b1000;
      cyc(1);
      player_input = 4'b0000;
      cyc(1);
      n_checks++;
      if (round_fail !== 1'b1 || round_won !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_wins: got fail=%b won=%b, required 1/0", round_fail, round_won);
      end
      // One cycle earlier the same press is accepted.
      do_reset();
      segment = '0; segment[0] = COL_BLUE;
      begin_round(6'd1);
      wait_input_phase("timeout_edge", 40);
      cyc(18);
      player_input = 4'b1000;
      cyc(1);
      player_input = 4'b0000;
      cyc(1);
      n_checks++;
      if (round_won !== 1'b1 || round_fail !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_last_ok: got won=%b fail=%b, required 1/0", round_won, round_fail);
      end
   endtask

   task automatic test_hold_timeout();
      do_reset();
      set_seg_base();
      begin_round(6'd3);
      wait_input_phase("hold", 40);
      player_input = 4'b0001;
      cyc(2);
      n_checks++;
      if (check_round !== 5'd1 || disp !== 4'b0001) begin
         n_fail++;
         $display("FAIL hold_step: got cr=%0d disp=%b, required 1/0001", check_round, disp);
      end
      cyc(19);
      n_checks++;
      if (round_fail !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_early: got fail=%b, required 0", round_fail);
      end
      cyc(1);
      n_checks++;
      if (round_fail !== 1'b1 || round_won !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_timeout: got fail=%b won=%b, required 1/0", round_fail, round_won);
      end
      player_input = 4'b0000;
   endtask

   task automatic test_len_zero();
      do_reset();
      set_seg_base();
      round_len = 6'd0; start = 1'b1;
      cyc(3);
      start = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || disp !== 4'b0000) begin
         n_fail++;
         $display("FAIL len_zero: got busy=%b disp=%b, required 0/0000", busy, disp);
      end
   endtask

   task automatic test_len_clamp();
      int on_cyc, rises, max_cr;
      logic [3:0] prev, last_lit;
      do_reset();
      for (int i = 0; i < MAX_STEPS; i++) segment[i] = 3'(i % 4);
      begin_round(6'd40);
      on_cyc = 0; rises = 0; max_cr = 0; prev = 4'b0000; last_lit = 4'b0000;
      for (int k = 0; k < 400 && input_phase !== 1'b1; k++) begin
         if (disp != 4'b0000) begin
            on_cyc++;
            last_lit = disp;
            if (prev == 4'b0000) rises++;
         end
         if (int'(check_round) > max_cr) max_cr = int'(check_round);
         prev = disp;
         cyc(1);
      end
      n_checks++;
      if (rises !== 32 || on_cyc !== 128 || max_cr !== 31 || last_lit !== 4'b1000 || input_phase !== 1'b1) begin
         n_fail++;
         $display("FAIL len_clamp: got flashes=%0d lit=%0d maxcr=%0d last=%b ip=%b, required 32/128/31/1000/1",
                  rises, on_cyc, max_cr, last_lit, input_phase);
      end
      cyc(25);
   endtask

   task automatic test_invalid_slot();
      logic [3:0] exp_d;
      do_reset();
      segment = '0; segment[0] = COL_RED; segment[1] = 3'b110;
      begin_round(6'd2);
      for (int s = 0; s < 12; s++) begin
         cyc(1);
         exp_d = (s < 4) ? 4'b0001 : 4'b0000;
         n_checks++;
         if (disp !== exp_d || check_round !== 5'(s / 6)) begin
            n_fail++;
            $display("FAIL invalid_slot%0d: got disp=%b cr=%0d, required %b/%0d", s, disp, check_round, exp_d, s / 6);
         end
      end
      wait_input_phase("invalid", 10);
      press1(4'b0001);
      player_input = 4'b0100;
      cyc(1);
      player_input = 4'b0000;
      cyc(1);
      n_checks++;
      if (round_fail !== 1'b1 || round_won !== 1'b0) begin
         n_fail++;
         $display("FAIL invalid_press: got fail=%b won=%b, required 1/0", round_fail, round_won);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_seg_base();
      begin_round(6'd3);
      cyc(2);
      n_checks++;
      if (disp !== 4'b0001 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset_pre: got disp=%b busy=%b, required 0001/1", disp, busy);
      end
      reset = 1'b1;
      cyc(1);
      n_checks++;
      if ({disp, check_round, busy, input_phase, round_won, round_fail} !== 13'd0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got disp=%b cr=%0d busy=%b ip=%b won=%b fail=%b, required all 0",
                  disp, check_round, busy, input_phase, round_won, round_fail);
      end
      reset = 1'b0;
      cyc(3);
      n_checks++;
      if (busy !== 1'b0 || disp !== 4'b0000) begin
         n_fail++;
         $display("FAIL midreset_idle: got busy=%b disp=%b, required 0/0000", busy, disp);
      end
   endtask

   task automatic test_start_busy();
      int on_cyc;
      logic bad_disp;
      do_reset();
      segment = '0; segment[0] = COL_BLUE;
      round_len = 6'd1; start = 1'b1;
      cyc(1);
      // Keep start high and change the inputs; the running round must not notice.
      round_len = 6'd3; segment[0] = COL_RED;
      on_cyc = 0; bad_disp = 1'b0;
      for (int k = 0; k < 60 && input_phase !== 1'b1; k++) begin
         if (disp != 4'b0000) begin
            on_cyc++;
            if (disp != 4'b1000) bad_disp = 1'b1;
         end
         cyc(1);
      end
      start = 1'b0;
      n_checks++;
      if (on_cyc !== 4 || bad_disp !== 1'b0 || input_phase !== 1'b1) begin
         n_fail++;
         $display("FAIL busy_start: got lit=%0d wrongcolour=%b ip=%b, required 4/0/1", on_cyc, bad_disp, input_phase);
      end
      player_input = 4'b1000;
      cyc(1);
      player_input = 4'b0000;
      cyc(1);
      n_checks++;
      if (round_won !== 1'b1) begin
         n_fail++;
         $display("FAIL busy_snapshot: got won=%b, required 1", round_won);
      end
   endtask

   initial begin
      test_reset();
      test_playback();
      test_win();
      test_wrong_press();
      test_multi_press();
      test_held_button();
      test_timeout();
      test_hold_timeout();
      test_len_zero();
      test_len_clamp();
      test_invalid_slot();
      test_reset_mid();
      test_start_busy();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete, required completion within 300000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/simon_sequencer.md
Name: simon_sequencer

Overview:
- Round controller for the Simon Says game.
- On start, plays the first N entries of the colour sequence onto the four LEDs with fixed on/off timing.
- Then collects player presses and checks each one against the same entries.
- Reports a win or fail pulse per round and drives the step index consumed by the LED flash logic.

Parameters:
ON_CYCLES, 4, clock cycles each colour is lit during playback (≥1)
OFF_CYCLES, 2, dark gap after each lit colour (≥1)
TIMEOUT_CYCLES, 20, max cycles spent waiting for or holding a press before fail (≥1)
MAX_STEPS, 32, sequence depth; fixes index width 5 and round_len width 6

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  begin a round; sampled only in IDLE
round_len  in  6  number of steps to play/check; latched on accepted start
segment  in  32x3  colour sequence; 3'b000..3'b011 = LED 0..3, 3'b1xx = invalid; snapshotted on accepted start
player_input  in  4  debounced, synchronised button levels, one bit per colour
disp  out  4  LED drive
check_round  out  5  current step index
busy  out  1  high in every state except IDLE
input_phase  out  1  high in RELEASE and WAIT_IN
round_won  out  1  one-cycle pulse
round_fail  out  1  one-cycle pulse

Behaviour:
- All outputs registered. Reset, including mid-round, forces IDLE with every output 0 at the next edge; latched data is discarded.
- States: IDLE, SHOW_ON, SHOW_OFF, RELEASE, WAIT_IN, WIN, FAIL.
- IDLE:
  - start=1 and round_len≠0: latch len=min(round_len,32) and the segment snapshot, set idx=0, go SHOW_ON.
  - round_len=0: start ignored.
  - start is ignored in every other state.
- SHOW_ON:
  - disp = one-hot of snap[idx], or 0 for an invalid code; the slot is still consumed.
  - Held exactly ON_CYCLES cycles, then SHOW_OFF.
  - disp is asserted on the first clock edge after the start-sampling edge.
- SHOW_OFF:
  - disp=0 for exactly OFF_CYCLES cycles.
  - If idx=len-1: set idx=0 and go RELEASE. Otherwise idx++ and go SHOW_ON.
- RELEASE:
  - Waits for player_input==0, then goes WAIT_IN.
  - A button held over from playback therefore never counts as a press.
- WAIT_IN:
  - The first cycle with player_input≠0 is the press.
  - Match when the press is exactly one-hot AND equals one-hot(snap[idx]).
  - Multi-bit press, wrong bit, or invalid snap[idx]: go FAIL.
  - Match with idx=len-1: go WIN. Match otherwise: idx++ and go RELEASE.
- Input-phase display: disp mirrors player_input, registered one cycle late.
- Timeout:
  - Counter clears on entry to RELEASE or WAIT_IN.
  - It counts in both states.
  - Reaching TIMEOUT_CYCLES goes FAIL. If the timeout and a press fall in the same cycle, the timeout wins.
- WIN / FAIL:
  - Single-cycle states that pulse round_won / round_fail with disp=0.
  - Next edge returns to IDLE with busy=0.
- check_round equals idx in SHOW_ON, SHOW_OFF, RELEASE and WAIT_IN; 0 in IDLE.
- Counter widths are $clog2(max(ON,OFF,TIMEOUT)+1). No wrap is possible because each counter clears on every state entry.

Decomposition:
- Package simon_pkg holds:
  - state enum seq_state_t
  - colour_t (3-bit) with constants COL_RED..COL_BLUE = 0..3
  - function colour_onehot(colour_t) returning 4'b0 for invalid codes
  - MAX_STEPS
- Sub-module seq_timer: loadable down-counter with a done flag, instanced once and shared by the on, off and timeout intervals.

Test Plan:
- Reset, then start with round_len=3 and segment[0..2]=0,2,1:
  - disp = 0001×4, 0000×2, 0100×4, 0000×2, 0010×4, 0000×2.
  - check_round = 0,1,2 over the matching slots; input_phase then rises.
- Same round, presses 0001, 0100, 0010 each followed by release → one round_won pulse, busy falls the next cycle, round_fail never asserts.
- Same round, second press 1000 → round_fail pulse on the cycle after that press; no round_won.
- Press 0101 on step 0 → round_fail. Holding 0001 from the end of playback does not count until released and pressed again.
- No press for 20 cycles in WAIT_IN → round_fail at exactly cycle 20. Holding a correct button for 20 cycles → round_fail.
- Edge cases:
  - round_len=0 → no busy.
  - round_len=40 → 32 steps played.
  - segment[1]=3'b110 → a dark ON slot, and any press at step 1 fails.
  - reset asserted mid-SHOW_ON → all outputs 0 next cycle.
  - start while busy → ignored.
